// File: rtl/yazmac_okuma_asamasi.sv
// Operand-read stage between decode and execute.
// Drives register-file read addresses, selects operands (x0 forced to zero,
// same-cycle writeback bypassed), and holds a registered bundle for execute.
// Handles one load-use bubble, downstream stall, flush, and refreshes held
// operands from writeback while stalled.
module yazmac_okuma_asamasi #(
  parameter int ADRES_BIT = 5
) (
  input  logic                 clk_g,
  input  logic                 rst_g,
  input  logic                 gecerli_g,
  output logic                 hazir_c,
  input  logic [ADRES_BIT-1:0] rs1_adres_g,
  input  logic [ADRES_BIT-1:0] rs2_adres_g,
  input  logic [ADRES_BIT-1:0] rd_adres_g,
  input  logic                 rd_yaz_g,
  input  logic                 yukle_g,
  input  logic [31:0]          buyruk_g,
  output logic [ADRES_BIT-1:0] ky1_adres_c,
  output logic [ADRES_BIT-1:0] ky2_adres_c,
  input  logic [31:0]          ky1_deger_g,
  input  logic [31:0]          ky2_deger_g,
  input  logic [ADRES_BIT-1:0] hy_adres_g,
  input  logic [31:0]          hy_deger_g,
  input  logic                 yaz_g,
  input  logic                 durdur_g,
  input  logic                 bosalt_g,
  output logic                 gecerli_c,
  output logic [31:0]          rs1_deger_c,
  output logic [31:0]          rs2_deger_c,
  output logic [ADRES_BIT-1:0] rd_adres_c,
  output logic                 rd_yaz_c,
  output logic                 yukle_c,
  output logic [31:0]          buyruk_c
);

  // Registered execute-side bundle
  logic                 vld_p1;
  logic [31:0]          rs1_deger_p1;
  logic [31:0]          rs2_deger_p1;
  logic [ADRES_BIT-1:0] rd_adres_p1;
  logic                 rd_yaz_p1;
  logic                 yukle_p1;
  logic [31:0]          buyruk_p1;
  logic [ADRES_BIT-1:0] rs1_adres_p1;
  logic [ADRES_BIT-1:0] rs2_adres_p1;

  logic ilerle;
  logic yuk_kullan;

  // x0 reads as zero; otherwise a same-cycle writeback wins over the file
  function automatic logic [31:0] islenen_sec(
    input logic [ADRES_BIT-1:0] adres,
    input logic [31:0]          dosya_deger,
    input logic                 yaz,
    input logic [ADRES_BIT-1:0] hy_adres,
    input logic [31:0]          hy_deger
  );
    if (adres == '0)
      islenen_sec = 32'd0;
    else if (yaz && (hy_adres == adres))
      islenen_sec = hy_deger;
    else
      islenen_sec = dosya_deger;
  endfunction

  // A held operand whose source is being written back picks up the new value
  function automatic logic [31:0] tazele(
    input logic [ADRES_BIT-1:0] adres,
    input logic [31:0]          eski,
    input logic                 yaz,
    input logic [ADRES_BIT-1:0] hy_adres,
    input logic [31:0]          hy_deger
  );
    if ((adres != '0) && yaz && (hy_adres == adres))
      tazele = hy_deger;
    else
      tazele = eski;
  endfunction

  assign ky1_adres_c = rs1_adres_g;
  assign ky2_adres_c = rs2_adres_g;

  // An invalid bundle can always be overwritten, so only a valid stalled one blocks
  assign ilerle = !durdur_g || !vld_p1;

  // Consumer directly behind a load waits one cycle for the loaded value
  assign yuk_kullan = vld_p1 && yukle_p1 && rd_yaz_p1 && (rd_adres_p1 != '0) &&
                      gecerli_g &&
                      ((rd_adres_p1 == rs1_adres_g) || (rd_adres_p1 == rs2_adres_g));

  assign hazir_c = ilerle && !yuk_kullan && !bosalt_g;

  // Stage boundary: capture, bubble, flush or hold the execute bundle
  always_ff @(posedge clk_g or posedge rst_g) begin
    if (rst_g) begin
      vld_p1       <= 1'b0;
      rs1_deger_p1 <= '0;
      rs2_deger_p1 <= '0;
      rd_adres_p1  <= '0;
      rd_yaz_p1    <= 1'b0;
      yukle_p1     <= 1'b0;
      buyruk_p1    <= '0;
      rs1_adres_p1 <= '0;
      rs2_adres_p1 <= '0;
    end else if (bosalt_g) begin
      vld_p1 <= 1'b0;
    end else if (ilerle) begin
      if (gecerli_g && !yuk_kullan) begin
        vld_p1       <= 1'b1;
        rs1_deger_p1 <= islenen_sec(rs1_adres_g, ky1_deger_g, yaz_g, hy_adres_g, hy_deger_g);
        rs2_deger_p1 <= islenen_sec(rs2_adres_g, ky2_deger_g, yaz_g, hy_adres_g, hy_deger_g);
        rd_adres_p1  <= rd_adres_g;
        rd_yaz_p1    <= rd_yaz_g;
        yukle_p1     <= yukle_g;
        buyruk_p1    <= buyruk_g;
        rs1_adres_p1 <= rs1_adres_g;
        rs2_adres_p1 <= rs2_adres_g;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else begin
      rs1_deger_p1 <= tazele(rs1_adres_p1, rs1_deger_p1, yaz_g, hy_adres_g, hy_deger_g);
      rs2_deger_p1 <= tazele(rs2_adres_p1, rs2_deger_p1, yaz_g, hy_adres_g, hy_deger_g);
    end
  end

  assign gecerli_c   = vld_p1;
  assign rs1_deger_c = rs1_deger_p1;
  assign rs2_deger_c = rs2_deger_p1;
  assign rd_adres_c  = rd_adres_p1;
  assign rd_yaz_c    = rd_yaz_p1;
  assign yukle_c     = yukle_p1;
  assign buyruk_c    = buyruk_p1;

endmodule

// File: tb/tb_yazmac_okuma_asamasi.sv
// Directed bench for the operand-read stage with a small register-file model.
module tb_yazmac_okuma_asamasi;

  localparam int ADRES_BIT = 5;

  logic                 clk_g = 1'b0;
  logic                 rst_g;
  logic                 gecerli_g;
  logic                 hazir_c;
  logic [ADRES_BIT-1:0] rs1_adres_g, rs2_adres_g, rd_adres_g;
  logic                 rd_yaz_g, yukle_g;
  logic [31:0]          buyruk_g;
  logic [ADRES_BIT-1:0] ky1_adres_c, ky2_adres_c;
  logic [31:0]          ky1_deger_g, ky2_deger_g;
  logic [ADRES_BIT-1:0] hy_adres_g;
  logic [31:0]          hy_deger_g;
  logic                 yaz_g, durdur_g, bosalt_g;
  logic                 gecerli_c;
  logic [31:0]          rs1_deger_c, rs2_deger_c;
  logic [ADRES_BIT-1:0] rd_adres_c;
  logic                 rd_yaz_c, yukle_c;
  logic [31:0]          buyruk_c;

  int kontrol_sayisi = 0;
  int hata_sayisi    = 0;

  logic [31:0] rf [0:31];

  yazmac_okuma_asamasi #(.ADRES_BIT(ADRES_BIT)) dut (
    .clk_g(clk_g), .rst_g(rst_g), .gecerli_g(gecerli_g), .hazir_c(hazir_c),
    .rs1_adres_g(rs1_adres_g), .rs2_adres_g(rs2_adres_g), .rd_adres_g(rd_adres_g),
    .rd_yaz_g(rd_yaz_g), .yukle_g(yukle_g), .buyruk_g(buyruk_g),
    .ky1_adres_c(ky1_adres_c), .ky2_adres_c(ky2_adres_c),
    .ky1_deger_g(ky1_deger_g), .ky2_deger_g(ky2_deger_g),
    .hy_adres_g(hy_adres_g), .hy_deger_g(hy_deger_g), .yaz_g(yaz_g),
    .durdur_g(durdur_g), .bosalt_g(bosalt_g), .gecerli_c(gecerli_c),
    .rs1_deger_c(rs1_deger_c), .rs2_deger_c(rs2_deger_c), .rd_adres_c(rd_adres_c),
    .rd_yaz_c(rd_yaz_c), .yukle_c(yukle_c), .buyruk_c(buyruk_c)
  );

  always #5 clk_g = ~clk_g;

  // Register file: no bypass, x0 is an ordinary storable entry
  always @(posedge clk_g) begin
    if (rst_g) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (yaz_g) begin
      rf[hy_adres_g] <= hy_deger_g;
    end
  end

  assign ky1_deger_g = rf[ky1_adres_c];
  assign ky2_deger_g = rf[ky2_adres_c];

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    kontrol_sayisi++;
    if (gozlenen !== beklenen) begin
      hata_sayisi++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", etiket, gozlenen, beklenen);
    end
  endtask

  task automatic tik();
    @(posedge clk_g);
    #1;
  endtask

  task automatic sun(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic rdy, input logic yk, input logic [31:0] b);
    gecerli_g = 1'b1; rs1_adres_g = rs1; rs2_adres_g = rs2; rd_adres_g = rd;
    rd_yaz_g = rdy; yukle_g = yk; buyruk_g = b;
  endtask

  task automatic dosya_yaz(input logic [4:0] a, input logic [31:0] d);
    gecerli_g = 1'b0; yaz_g = 1'b1; hy_adres_g = a; hy_deger_g = d;
    tik();
    yaz_g = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_g = 1'b1; gecerli_g = 0; rs1_adres_g = 0; rs2_adres_g = 0; rd_adres_g = 0;
    rd_yaz_g = 0; yukle_g = 0; buyruk_g = 0; hy_adres_g = 0; hy_deger_g = 0;
    yaz_g = 0; durdur_g = 0; bosalt_g = 0;
    tik(); tik();
    kontrol("reset_gecerli", {31'd0, gecerli_c}, 32'd0);
    kontrol("reset_rs1", rs1_deger_c, 32'd0);
    kontrol("reset_buyruk", buyruk_c, 32'd0);
    rst_g = 1'b0;
    #1;
    kontrol("reset_hazir", {31'd0, hazir_c}, 32'd1);

    // Populate the file through the writeback port
    dosya_yaz(5'd5, 32'h11);
    dosya_yaz(5'd3, 32'h33);
    dosya_yaz(5'd4, 32'h44);
    dosya_yaz(5'd7, 32'h70);

    // Same-cycle writeback bypass
    sun(5'd5, 5'd3, 5'd9, 1'b1, 1'b0, 32'h100);
    yaz_g = 1'b1; hy_adres_g = 5'd5; hy_deger_g = 32'hAA;
    tik();
    yaz_g = 1'b0; gecerli_g = 1'b0;
    kontrol("bypass_gecerli", {31'd0, gecerli_c}, 32'd1);
    kontrol("bypass_rs1", rs1_deger_c, 32'hAA);
    kontrol("bypass_rs2", rs2_deger_c, 32'h33);
    kontrol("bypass_rd", {27'd0, rd_adres_c}, 32'd9);
    kontrol("bypass_buyruk", buyruk_c, 32'h100);

    // x0 forced to zero even when the file holds a nonzero x0
    dosya_yaz(5'd0, 32'hDEAD);
    sun(5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 32'h110);
    tik();
    kontrol("x0_rs1", rs1_deger_c, 32'd0);
    kontrol("x0_rs2", rs2_deger_c, 32'd0);
    sun(5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 32'h120);
    yaz_g = 1'b1; hy_adres_g = 5'd0; hy_deger_g = 32'h77;
    tik();
    yaz_g = 1'b0;
    kontrol("x0_yaz_rs1", rs1_deger_c, 32'd0);
    kontrol("x0_yaz_rs2", rs2_deger_c, 32'd0);
    kontrol("x0_yaz_buyruk", buyruk_c, 32'h120);

    // Load-use: one bubble then acceptance
    sun(5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 32'h200);
    tik();
    kontrol("yukle_gecerli", {31'd0, gecerli_c}, 32'd1);
    kontrol("yukle_bayrak", {31'd0, yukle_c}, 32'd1);
    sun(5'd4, 5'd7, 5'd8, 1'b1, 1'b0, 32'h300);
    #1;
    kontrol("yk_hazir_0", {31'd0, hazir_c}, 32'd0);
    tik();
    kontrol("yk_balon", {31'd0, gecerli_c}, 32'd0);
    kontrol("yk_hazir_1", {31'd0, hazir_c}, 32'd1);
    tik();
    gecerli_g = 1'b0;
    kontrol("yk_kabul_gecerli", {31'd0, gecerli_c}, 32'd1);
    kontrol("yk_kabul_buyruk", buyruk_c, 32'h300);
    kontrol("yk_kabul_rs1", rs1_deger_c, 32'h44);
    kontrol("yk_kabul_rs2", rs2_deger_c, 32'h70);

    // Held bundle refreshed by a writeback during stall
    sun(5'd3, 5'd4, 5'd10, 1'b1, 1'b0, 32'h400);
    tik();
    kontrol("tut_rs1_ilk", rs1_deger_c, 32'h33);
    sun(5'd5, 5'd6, 5'd11, 1'b1, 1'b0, 32'h500);
    durdur_g = 1'b1;
    yaz_g = 1'b1; hy_adres_g = 5'd3; hy_deger_g = 32'h55;
    #1;
    kontrol("tut_hazir", {31'd0, hazir_c}, 32'd0);
    tik();
    yaz_g = 1'b0; gecerli_g = 1'b0; durdur_g = 1'b0;
    #1;
    kontrol("tut_gecerli", {31'd0, gecerli_c}, 32'd1);
    kontrol("tut_rs1_tazele", rs1_deger_c, 32'h55);
    kontrol("tut_rs2", rs2_deger_c, 32'h44);
    kontrol("tut_buyruk", buyruk_c, 32'h400);
    tik();
    kontrol("tut_sonra_balon", {31'd0, gecerli_c}, 32'd0);

    // Flush overrides stall and drops the offered instruction
    sun(5'd5, 5'd0, 5'd12, 1'b1, 1'b0, 32'h600);
    tik();
    kontrol("bosalt_once", {31'd0, gecerli_c}, 32'd1);
    sun(5'd3, 5'd0, 5'd13, 1'b1, 1'b0, 32'h700);
    durdur_g = 1'b1; bosalt_g = 1'b1;
    #1;
    kontrol("bosalt_hazir", {31'd0, hazir_c}, 32'd0);
    tik();
    bosalt_g = 1'b0; durdur_g = 1'b0; gecerli_g = 1'b0;
    kontrol("bosalt_gecerli", {31'd0, gecerli_c}, 32'd0);
    tik();
    kontrol("bosalt_dusuruldu", {31'd0, gecerli_c}, 32'd0);
    kontrol("bosalt_buyruk_ayni", buyruk_c, 32'h600);

    // Asynchronous reset while a valid bundle is stalled
    sun(5'd4, 5'd5, 5'd14, 1'b1, 1'b1, 32'h800);
    tik();
    gecerli_g = 1'b0; durdur_g = 1'b1;
    tik();
    kontrol("ars_oncesi", {31'd0, gecerli_c}, 32'd1);
    #2;
    rst_g = 1'b1;
    #1;
    kontrol("ars_gecerli", {31'd0, gecerli_c}, 32'd0);
    kontrol("ars_rs1", rs1_deger_c, 32'd0);
    kontrol("ars_rs2", rs2_deger_c, 32'd0);
    kontrol("ars_rd", {27'd0, rd_adres_c}, 32'd0);
    kontrol("ars_yukle", {31'd0, yukle_c}, 32'd0);
    kontrol("ars_buyruk", buyruk_c, 32'd0);
    tik();
    rst_g = 1'b0; durdur_g = 1'b0;
    #1;
    kontrol("ars_sonra_hazir", {31'd0, hazir_c}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", kontrol_sayisi, hata_sayisi);
    $finish;
  end

endmodule
